srambank_arb2: RTL and testbench
================================

SRAMBANK_ARB2 -- requirements
Module: srambank_arb2

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word-address width (depth 2^ADDR_W = 1024).
REQ-002 Parameter DATA_W, default 40, SHALL set the data word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 pN_req  input  1  (N=0,1) SHALL be the requester-N access request.
REQ-006 pN_we  input  1  SHALL select the access type: 1 = write, 0 = read.
REQ-007 pN_addr  input  ADDR_W  SHALL be the requester-N word address.
REQ-008 pN_wd  input  DATA_W  SHALL be the requester-N write data.
REQ-009 pN_ready  output  1  SHALL indicate acceptance of the pN request in the current cycle.
REQ-010 pN_rvalid  output  1  SHALL be a one-cycle pulse marking valid read data for requester N.
REQ-011 pN_rdata  output  DATA_W  SHALL carry sram_dataout unmodified.
REQ-012 sram_addr, sram_wd, sram_banksel, sram_read, sram_write  outputs  ADDR_W/DATA_W/1/1/1  SHALL drive the SRAM bank ports.
REQ-013 sram_dataout  input  DATA_W  SHALL be the registered SRAM read data, valid from the cycle after a read is issued.
REQ-014 init_done  output  1  SHALL be high once memory clear is complete.

Function
REQ-015 The FSM SHALL have two states, INIT and RUN; reset enters INIT.
REQ-016 In INIT, each cycle: sram_banksel=1, sram_write=1, sram_read=0, sram_addr=init counter, sram_wd=0; the counter increments from 0 to 2^ADDR_W-1.
REQ-017 After the write to address 2^ADDR_W-1, the FSM SHALL enter RUN on the next edge; init_done rises in the first RUN cycle (1024 INIT cycles at default).
REQ-018 In INIT, p0_ready and p1_ready SHALL be 0 regardless of pN_req.
REQ-019 In RUN, at most one request SHALL be accepted per cycle.
REQ-020 A single active request SHALL be accepted in the same cycle (combinational ready).
REQ-021 When both requests are active, the port indicated by the priority pointer SHALL win; the pointer SHALL then point to the other port.
REQ-022 An uncontested grant SHALL set the pointer to the non-granted port.
REQ-023 An accepted request SHALL drive sram_banksel=1, sram_addr=pN_addr, and either sram_write=1 with sram_wd=pN_wd (we=1) or sram_read=1 (we=0) in that same cycle.
REQ-024 sram_read and sram_write SHALL never both be 1.
REQ-025 With no acceptance in RUN, sram_banksel, sram_read and sram_write SHALL be 0.
REQ-026 An accepted read SHALL produce pN_rvalid=1 for exactly the following cycle, on the issuing port only.
REQ-027 Back-to-back reads on alternating ports SHALL produce alternating rvalid pulses with no gaps.
REQ-028 A read followed by a write to the same address SHALL return the pre-write data.
REQ-029 A pending requester SHALL hold req, we, addr and wd stable until ready; a denied request produces no side effect.

Reset
REQ-030 Asserting reset SHALL immediately force: state=INIT, init counter=0, pointer=port 0, p0_rvalid=p1_rvalid=0, init_done=0, pN_ready=0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL abandon the operation in flight; a read issued in the cycle reset rises SHALL produce no rvalid.
REQ-032 After reset deasserts, a full INIT sequence SHALL rerun from address 0.

Structure
REQ-033 Package srambank_pkg SHALL hold ADDR_W and DATA_W defaults, DEPTH, and the INIT/RUN state enum.
REQ-034 Two-way round-robin arbitration SHALL be a sub-module, rr_arb2 (req[1:0], pointer -> grant[1:0], pointer update).
REQ-035 The SRAM bank itself SHALL be external to this block.

Verification
REQ-036 Release reset, hold p0_req=1 -> p0_ready=0 for 1024 cycles, sram_write=1 with addr 0..1023 and wd=0, init_done=1 in cycle 1025.
REQ-037 RUN; p0 write addr 5 = 0x12_3456_789A, then p1 read addr 5 -> p1_rvalid one cycle later with p1_rdata=0x123456789A, p0_rvalid stays 0.
REQ-038 Both ports request every cycle for 8 cycles after reset -> grants p0,p1,p0,p1,...; neither port is starved.
REQ-039 p0 read addr 7 (holding 0xAA), p1 write addr 7 = 0xBB next cycle -> p0_rdata=0xAA; a later read returns 0xBB.
REQ-040 Assert reset during RUN, in the cycle a read is accepted -> no rvalid; INIT restarts at addr 0; memory reads 0 afterwards.
REQ-041 Any cycle -> assert sram_read & sram_write never both 1, and p0_ready & p1_ready never both 1.

Source files
------------

// File: rtl/srambank_pkg.sv
// rtl/srambank_pkg.sv - shared widths, depth and FSM state type for the SRAM bank arbiter
package srambank_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 40;
    localparam int DEPTH      = 1 << DEF_ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with pointer update
module rr_arb2 (
    input  logic       en,
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       ptr_nxt
);

    // Grant one requester; the pointer always moves to the port that lost or did not ask
    always_comb begin
        grant   = 2'b00;
        ptr_nxt = ptr;
        if (en) begin
            case (req)
                2'b01: begin
                    grant   = 2'b01;
                    ptr_nxt = 1'b1;
                end
                2'b10: begin
                    grant   = 2'b10;
                    ptr_nxt = 1'b0;
                end
                2'b11: begin
                    if (ptr == 1'b0) begin
                        grant   = 2'b01;
                        ptr_nxt = 1'b1;
                    end else begin
                        grant   = 2'b10;
                        ptr_nxt = 1'b0;
                    end
                end
                default: begin
                    grant   = 2'b00;
                    ptr_nxt = ptr;
                end
            endcase
        end
    end

endmodule

// File: rtl/srambank_arb2.sv
// rtl/srambank_arb2.sv - clears an external SRAM bank, then arbitrates two requesters onto it
module srambank_arb2
    import srambank_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wd,
    output logic              p0_ready,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wd,
    output logic              p1_ready,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wd,
    output logic              sram_banksel,
    output logic              sram_read,
    output logic              sram_write,
    input  logic [DATA_W-1:0] sram_dataout,

    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              ptr_q, ptr_d;
    logic              p0_rvalid_q, p0_rvalid_d;
    logic              p1_rvalid_q, p1_rvalid_d;
    logic              init_done_q, init_done_d;

    logic [1:0]        grant;
    logic              ptr_nxt;

    rr_arb2 u_arb (
        .en      (state_q == ST_RUN),
        .req     ({p1_req, p0_req}),
        .ptr     (ptr_q),
        .grant   (grant),
        .ptr_nxt (ptr_nxt)
    );

    assign p0_ready  = grant[0];
    assign p1_ready  = grant[1];
    assign p0_rdata  = sram_dataout;
    assign p1_rdata  = sram_dataout;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign init_done = init_done_q;

    // Next-state: walk the clear counter in INIT, track arbitration pointer and read pulses in RUN
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ptr_d       = ptr_q;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                ptr_d       = ptr_nxt;
                p0_rvalid_d = grant[0] & ~p0_we;
                p1_rvalid_d = grant[1] & ~p1_we;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // SRAM port mux: clear writes during INIT, otherwise the granted requester or idle
    always_comb begin
        sram_addr    = '0;
        sram_wd      = '0;
        sram_banksel = 1'b0;
        sram_read    = 1'b0;
        sram_write   = 1'b0;
        if (state_q == ST_INIT) begin
            sram_addr    = init_cnt_q;
            sram_banksel = 1'b1;
            sram_write   = 1'b1;
        end else if (grant[0]) begin
            sram_addr    = p0_addr;
            sram_wd      = p0_wd;
            sram_banksel = 1'b1;
            sram_write   = p0_we;
            sram_read    = ~p0_we;
        end else if (grant[1]) begin
            sram_addr    = p1_addr;
            sram_wd      = p1_wd;
            sram_banksel = 1'b1;
            sram_write   = p1_we;
            sram_read    = ~p1_we;
        end
    end

    // FSM and registered status; reset abandons any access in flight and restarts the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            ptr_q       <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            ptr_q       <= ptr_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            init_done_q <= init_done_d;
        end
    end

endmodule

// File: tb/tb_srambank_arb2.sv
// tb/tb_srambank_arb2.sv - directed vector bench for srambank_arb2 with a behavioural SRAM
module tb_srambank_arb2;

    localparam int AW = 10;
    localparam int DW = 40;

    logic          clk;
    logic          reset;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wd, p1_wd;
    logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wd;
    logic          sram_banksel, sram_read, sram_write;
    logic [DW-1:0] sram_dataout;
    logic          init_done;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks;
    int errors;

    typedef struct {
        logic          r0;
        logic          w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1;
        logic          w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          g0;
        logic          g1;
        logic          v0;
        logic          v1;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t vecs[$];

    srambank_arb2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .p0_req       (p0_req),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wd        (p0_wd),
        .p0_ready     (p0_ready),
        .p0_rvalid    (p0_rvalid),
        .p0_rdata     (p0_rdata),
        .p1_req       (p1_req),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wd        (p1_wd),
        .p1_ready     (p1_ready),
        .p1_rvalid    (p1_rvalid),
        .p1_rdata     (p1_rdata),
        .sram_addr    (sram_addr),
        .sram_wd      (sram_wd),
        .sram_banksel (sram_banksel),
        .sram_read    (sram_read),
        .sram_write   (sram_write),
        .sram_dataout (sram_dataout),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM bank: registered read data, valid the cycle after the read
    initial sram_dataout = '0;
    always @(posedge clk) begin
        if (sram_banksel && sram_write) mem[sram_addr] <= sram_wd;
        if (sram_banksel && sram_read) sram_dataout <= mem[sram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Invariants checked every cycle outside reset
    always @(negedge clk) begin
        if (!reset) begin
            chk("rd_wr_exclusive", {63'd0, sram_read & sram_write}, 64'd0);
            chk("ready_exclusive", {63'd0, p0_ready & p1_ready}, 64'd0);
        end
    end

    task automatic add(input logic r0, input logic w0, input int a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input int a1, input logic [DW-1:0] d1,
                       input logic g0, input logic g1, input logic v0, input logic v1,
                       input logic [DW-1:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0[AW-1:0]; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1[AW-1:0]; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wd = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wd = '0;
    endtask

    // Entered at posedge+1 of the first INIT cycle; leaves at posedge+1 of the first RUN cycle
    task automatic run_init();
        for (int i = 0; i < (1 << AW); i++) begin
            @(negedge clk);
            chk("init_cycle", {48'd0, p0_ready, p1_ready, sram_banksel, sram_write, sram_read,
                               init_done, sram_addr},
                {48'd0, 6'b001100, i[AW-1:0]});
            chk("init_wd", {24'd0, sram_wd}, 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset  = 1'b1;

        // Priority/contention sequences starting from pointer = port 0, memory all zero
        for (int i = 0; i < 8; i++)
            add(1, 0, 1, 40'd0, 1, 0, 2, 40'd0, (i % 2) == 0, (i % 2) == 1,
                (i > 0) && ((i % 2) == 1), (i > 0) && ((i % 2) == 0), 40'd0);
        add(1, 1, 5, 40'h12_3456_789A, 0, 0, 0, 40'd0, 1, 0, 0, 1, 40'd0);
        add(0, 0, 0, 40'd0, 1, 0, 5, 40'd0, 0, 1, 0, 0, 40'd0);
        add(0, 0, 0, 40'd0, 0, 0, 0, 40'd0, 0, 0, 0, 1, 40'h12_3456_789A);
        add(0, 0, 0, 40'd0, 1, 1, 7, 40'hAA, 0, 1, 0, 0, 40'd0);
        add(1, 0, 7, 40'd0, 0, 0, 0, 40'd0, 1, 0, 0, 0, 40'd0);
        add(0, 0, 0, 40'd0, 1, 1, 7, 40'hBB, 0, 1, 1, 0, 40'hAA);
        add(1, 0, 7, 40'd0, 0, 0, 0, 40'd0, 1, 0, 0, 0, 40'd0);
        add(0, 0, 0, 40'd0, 0, 0, 0, 40'd0, 0, 0, 1, 0, 40'hBB);
        add(0, 0, 0, 40'd0, 1, 0, 5, 40'd0, 0, 1, 0, 0, 40'd0);
        add(1, 1, 9, 40'h55, 1, 0, 9, 40'd0, 1, 0, 0, 1, 40'h12_3456_789A);
        add(1, 0, 5, 40'd0, 1, 0, 9, 40'd0, 0, 1, 0, 0, 40'd0);
        add(1, 0, 5, 40'd0, 0, 0, 0, 40'd0, 1, 0, 0, 1, 40'h55);
        add(0, 0, 0, 40'd0, 0, 0, 0, 40'd0, 0, 0, 1, 0, 40'h12_3456_789A);

        // Reset state, with p0 already requesting
        p0_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {59'd0, p0_ready, p1_ready, p0_rvalid, p1_rvalid, init_done}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_init();
        p0_req = 1'b0;
        @(negedge clk);
        chk("init_done_first_run", {63'd0, init_done}, 64'd1);
        chk("run_idle_sram", {61'd0, sram_banksel, sram_read, sram_write}, 64'd0);
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            p0_req = vecs[k].r0; p0_we = vecs[k].w0; p0_addr = vecs[k].a0; p0_wd = vecs[k].d0;
            p1_req = vecs[k].r1; p1_we = vecs[k].w1; p1_addr = vecs[k].a1; p1_wd = vecs[k].d1;
            @(negedge clk);
            chk($sformatf("v%0d_ready", k), {62'd0, p0_ready, p1_ready},
                {62'd0, vecs[k].g0, vecs[k].g1});
            chk($sformatf("v%0d_rvalid", k), {62'd0, p0_rvalid, p1_rvalid},
                {62'd0, vecs[k].v0, vecs[k].v1});
            if (vecs[k].v0) chk($sformatf("v%0d_p0_rdata", k), {24'd0, p0_rdata}, {24'd0, vecs[k].rd});
            if (vecs[k].v1) chk($sformatf("v%0d_p1_rdata", k), {24'd0, p1_rdata}, {24'd0, vecs[k].rd});
            if (vecs[k].g0) begin
                chk($sformatf("v%0d_sram_ctl", k), {61'd0, sram_banksel, sram_read, sram_write},
                    {61'd0, 1'b1, ~vecs[k].w0, vecs[k].w0});
                chk($sformatf("v%0d_sram_addr", k), {54'd0, sram_addr}, {54'd0, vecs[k].a0});
                if (vecs[k].w0) chk($sformatf("v%0d_sram_wd", k), {24'd0, sram_wd}, {24'd0, vecs[k].d0});
            end else if (vecs[k].g1) begin
                chk($sformatf("v%0d_sram_ctl", k), {61'd0, sram_banksel, sram_read, sram_write},
                    {61'd0, 1'b1, ~vecs[k].w1, vecs[k].w1});
                chk($sformatf("v%0d_sram_addr", k), {54'd0, sram_addr}, {54'd0, vecs[k].a1});
                if (vecs[k].w1) chk($sformatf("v%0d_sram_wd", k), {24'd0, sram_wd}, {24'd0, vecs[k].d1});
            end else begin
                chk($sformatf("v%0d_sram_idle", k), {61'd0, sram_banksel, sram_read, sram_write}, 64'd0);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // Reset raised in the same cycle a read is accepted
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'd5;
        @(negedge clk);
        chk("pre_reset_accept", {62'd0, p0_ready, sram_read}, {62'd0, 2'b11});
        #1;
        reset = 1'b1;
        #1;
        chk("reset_async", {60'd0, p0_ready, sram_read, init_done, sram_write}, {60'd0, 4'b0001});
        chk("reset_async_addr", {54'd0, sram_addr}, 64'd0);
        @(posedge clk);
        #1;
        chk("reset_no_rvalid", {62'd0, p0_rvalid, p1_rvalid}, 64'd0);
        p0_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_init();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'd5;
        @(negedge clk);
        chk("reinit_done_ready", {62'd0, init_done, p0_ready}, {62'd0, 2'b11});
        @(posedge clk);
        #1;
        p0_req = 1'b0;
        @(negedge clk);
        chk("reinit_rvalid", {62'd0, p0_rvalid, p1_rvalid}, {62'd0, 2'b10});
        chk("reinit_cleared", {24'd0, p0_rdata}, 64'd0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
